// File: rtl/baseband_capture.sv
// Baseband I/Q capture buffer: arms, triggers on a level crossing or immediately, and stores a 2**AW deep record read back by the CPU.
// Optional pre-trigger history is enabled by defining CAPTURE_PRETRIG_EN.
module baseband_capture #(
    parameter int DW      = 16,
    parameter int AW      = 10,
    parameter int PRETRIG = 128
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     s_x,
    input  logic [DW-1:0]     s_y,
    input  logic              s_ce,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_mode,
    input  logic [DW-1:0]     trig_level,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [2*DW-1:0]   rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [AW:0]       wr_count
);

    localparam int DEPTH = 1 << AW;

    if (PRETRIG >= DEPTH) begin : g_pretrig_range
        $error("baseband_capture: PRETRIG must be less than 2**AW");
    end

`ifdef CAPTURE_PRETRIG_EN
    localparam int CAP_LEN = DEPTH - PRETRIG;
    localparam logic [AW:0]   PRE_CNT  = (AW+1)'(PRETRIG);
    localparam logic [AW-1:0] PRE_ADDR = AW'(PRETRIG);
`else
    localparam int CAP_LEN = DEPTH;
`endif
    localparam logic [AW:0] LAST_CNT = (AW+1)'(CAP_LEN - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                 state;
    logic [AW-1:0]          wr_ptr;
    logic signed [DW-1:0]   prev_x;
    logic                   prev_vld;
    logic                   x_rise;
    logic                   trig_hit;
    logic                   wr_en;
    logic [AW-1:0]          rd_ram_addr;

    logic [2*DW-1:0]        mem [DEPTH];
    logic [2*DW-1:0]        ram_q_p1;
    logic                   vld_p1;
    logic [2*DW-1:0]        rd_data_p2;
    logic                   vld_p2;

`ifdef CAPTURE_PRETRIG_EN
    logic [AW:0]            arm_cnt;
    logic [AW-1:0]          rec_start;
    logic                   pre_full;

    assign pre_full    = (arm_cnt >= PRE_CNT);
    assign rd_ram_addr = rd_addr + rec_start;
`else
    assign rd_ram_addr = rd_addr;
`endif

    always_comb begin
        x_rise   = prev_vld && (prev_x < $signed(trig_level)) && ($signed(s_x) >= $signed(trig_level));
        trig_hit = 1'b0;
        wr_en    = 1'b0;
        // arm, abort and reset all take precedence over any sample in the same cycle
        if (rst_n && !arm && !abort && s_ce) begin
            case (state)
                ARMED: begin
`ifdef CAPTURE_PRETRIG_EN
                    trig_hit = pre_full && (trig_mode ? x_rise : 1'b1);
                    wr_en    = 1'b1;
`else
                    trig_hit = trig_mode ? x_rise : 1'b1;
                    wr_en    = trig_hit;
`endif
                end
                CAPTURE: wr_en = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
            wr_count  <= '0;
            wr_ptr    <= '0;
            prev_vld  <= 1'b0;
`ifdef CAPTURE_PRETRIG_EN
            arm_cnt   <= '0;
            rec_start <= '0;
`endif
        end else if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else if (arm) begin
            state     <= ARMED;
            busy      <= 1'b1;
            triggered <= 1'b0;
            done      <= 1'b0;
            wr_count  <= '0;
            wr_ptr    <= '0;
            prev_vld  <= 1'b0;
`ifdef CAPTURE_PRETRIG_EN
            arm_cnt   <= '0;
            rec_start <= '0;
`endif
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case (state)
                ARMED: if (s_ce) begin
                    prev_vld <= 1'b1;
`ifdef CAPTURE_PRETRIG_EN
                    if (!pre_full) begin
                        arm_cnt <= arm_cnt + 1'b1;
                    end
`endif
                    if (trig_hit) begin
                        state     <= CAPTURE;
                        triggered <= 1'b1;
                        wr_count  <= (AW+1)'(1);
`ifdef CAPTURE_PRETRIG_EN
                        rec_start <= wr_ptr - PRE_ADDR;
`endif
                    end
                end
                CAPTURE: if (s_ce) begin
                    wr_count <= wr_count + 1'b1;
                    if (wr_count == LAST_CNT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (state == ARMED && s_ce) begin
            prev_x <= $signed(s_x);
        end
    end

    // Stage p1: RAM write and registered read (read-before-write on collision)
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_x, s_y};
        end
        if (rd_en) begin
            ram_q_p1 <= mem[rd_ram_addr];
        end
    end

    // Stage p2: output register, holds between reads
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            rd_data_p2 <= '0;
        end else begin
            vld_p1 <= rd_en;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                rd_data_p2 <= ram_q_p1;
            end
        end
    end

    assign rd_data  = rd_data_p2;
    assign rd_valid = vld_p2;

endmodule

// File: tb/tb_baseband_capture.sv
// Directed bench for baseband_capture: trigger modes, abort/arm priority, reset, and read pipeline timing.
module tb_baseband_capture;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int PRETRIG = 128;

    logic              sys_clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     s_x, s_y;
    logic              s_ce;
    logic              arm, abort;
    logic              trig_mode;
    logic [DW-1:0]     trig_level;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [2*DW-1:0]   rd_data;
    logic              rd_valid;
    logic              busy, triggered, done;
    logic [AW:0]       wr_count;

    int tests = 0;
    int fails = 0;

    baseband_capture #(.DW(DW), .AW(AW), .PRETRIG(PRETRIG)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .s_x(s_x), .s_y(s_y), .s_ce(s_ce),
        .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_level(trig_level),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .triggered(triggered), .done(done), .wr_count(wr_count)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] word(input int x, input int y);
        return {x[15:0], y[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic feed(input int x, input int y);
        s_x  = x[15:0];
        s_y  = y[15:0];
        s_ce = 1'b1;
        tick();
        s_ce = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int idx, input logic [31:0] exp);
        rd_addr = idx[AW-1:0];
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
        check({tag, "_v_n1"}, rd_valid, 1'b0);
        tick();
        check({tag, "_v_n2"}, rd_valid, 1'b1);
        check(tag, rd_data, exp);
        tick();
        check({tag, "_v_n3"}, rd_valid, 1'b0);
        check({tag, "_hold"}, rd_data, exp);
    endtask

    initial begin
        int bad_busy, bad_trig, bad_cnt;
        rst_n = 1'b0; s_x = '0; s_y = '0; s_ce = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_mode = 1'b0; trig_level = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_trig", triggered, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wrcnt", wr_count, 11'd0);
        check("rst_rdv", rd_valid, 1'b0);
        check("rst_rdd", rd_data, 32'd0);

`ifdef CAPTURE_PRETRIG_EN
        trig_mode = 1'b1; trig_level = 16'd50;
        pulse_arm();
        for (int n = 0; n < 60; n++) feed(n, -n);
        check("pre_early_trig", triggered, 1'b0);
        trig_level = 16'd500;
        for (int n = 60; n < 500; n++) feed(n, -n);
        check("pre_before_500", triggered, 1'b0);
        feed(500, -500);
        check("pre_trig", triggered, 1'b1);
        check("pre_cnt1", wr_count, 11'd1);
        for (int n = 501; n < 1395; n++) feed(n, -n);
        check("pre_done_early", done, 1'b0);
        check("pre_cnt895", wr_count, 11'd895);
        feed(1395, -1395);
        check("pre_done", done, 1'b1);
        check("pre_cnt896", wr_count, 11'd896);
        read_chk("pre_idx0", 0, word(372, -372));
        read_chk("pre_idx128", 128, word(500, -500));
        read_chk("pre_idx1023", 1023, word(1395, -1395));
`else
        // immediate trigger, full record
        trig_mode = 1'b0;
        pulse_arm();
        check("imm_busy", busy, 1'b1);
        check("imm_trig0", triggered, 1'b0);
        for (int n = 0; n < 1023; n++) feed(n, -n);
        check("imm_done_early", done, 1'b0);
        check("imm_cnt1023", wr_count, 11'd1023);
        check("imm_trig", triggered, 1'b1);
        feed(1023, -1023);
        check("imm_done", done, 1'b1);
        check("imm_busy_off", busy, 1'b0);
        check("imm_cnt1024", wr_count, 11'd1024);
        feed(7777, 7777);
        check("imm_done_ignore_cnt", wr_count, 11'd1024);
        read_chk("imm_idx5", 5, 32'h0005FFFB);
        read_chk("imm_idx0", 0, word(0, 0));
        rd_en = 1'b1; rd_addr = 10'd0; tick();
        rd_addr = 10'd1023; tick();
        rd_en = 1'b0;
        check("b2b_v1", rd_valid, 1'b1);
        check("b2b_d1", rd_data, word(0, 0));
        tick();
        check("b2b_v2", rd_valid, 1'b1);
        check("b2b_d2", rd_data, 32'h03FFFC01);
        tick();
        check("b2b_v3", rd_valid, 1'b0);

        // level trigger on rising crossing of 100
        trig_mode = 1'b1; trig_level = 16'd100;
        pulse_arm();
        check("lvl_done_clr", done, 1'b0);
        check("lvl_cnt_clr", wr_count, 11'd0);
        for (int k = 0; k < 10; k++) feed(10*k, -10*k);
        check("lvl_no_trig", triggered, 1'b0);
        check("lvl_cnt0", wr_count, 11'd0);
        feed(100, -100);
        check("lvl_trig", triggered, 1'b1);
        check("lvl_cnt1", wr_count, 11'd1);
        for (int k = 11; k < 1034; k++) feed(10*k, -10*k);
        check("lvl_done", done, 1'b1);
        check("lvl_cnt", wr_count, 11'd1024);
        read_chk("lvl_idx0", 0, word(100, -100));
        read_chk("lvl_idx1023", 1023, word(10330, -10330));

        // constant input above level never crosses
        trig_level = 16'd100;
        pulse_arm();
        bad_busy = 0; bad_trig = 0; bad_cnt = 0;
        for (int n = 0; n < 5000; n++) begin
            feed(500, n);
            if (busy !== 1'b1) bad_busy++;
            if (triggered !== 1'b0) bad_trig++;
            if (wr_count !== 11'd0) bad_cnt++;
        end
        check("nox_busy_bad", bad_busy, 0);
        check("nox_trig_bad", bad_trig, 0);
        check("nox_cnt_bad", bad_cnt, 0);

        // abort wins over arm in the same cycle
        trig_mode = 1'b0;
        pulse_arm();
        for (int n = 0; n < 300; n++) feed(3000 + n, n);
        check("ab_cnt300", wr_count, 11'd300);
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        check("ab_busy", busy, 1'b0);
        check("ab_done", done, 1'b0);
        check("ab_trig", triggered, 1'b0);
        tick();
        check("ab_idle_busy", busy, 1'b0);
        pulse_arm();
        check("re_busy", busy, 1'b1);
        for (int n = 0; n < 7; n++) feed(4000 + n, n);
        rd_addr = 10'd7; rd_en = 1'b1;
        feed(4007, 7);
        rd_en = 1'b0;
        feed(4008, 8);
        check("coll_v", rd_valid, 1'b1);
        check("coll_old", rd_data, word(3007, 7));
        for (int n = 9; n < 1024; n++) feed(4000 + n, n);
        check("re_done", done, 1'b1);
        check("re_cnt", wr_count, 11'd1024);
        read_chk("re_idx7", 7, word(4007, 7));

        // reset in the middle of a capture
        pulse_arm();
        for (int n = 0; n < 100; n++) feed(16'h1000 + n, 0);
        check("mr_trig_pre", triggered, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_busy", busy, 1'b0);
        check("mr_trig", triggered, 1'b0);
        check("mr_done", done, 1'b0);
        check("mr_cnt", wr_count, 11'd0);
        check("mr_rdv", rd_valid, 1'b0);
        check("mr_rdd", rd_data, 32'd0);
        feed(16'h7777, 16'h1111);
        check("mr_post_cnt", wr_count, 11'd0);
        check("mr_post_busy", busy, 1'b0);
        read_chk("mr_idx0", 0, word(16'h1000, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
